muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
// Sequences multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO for the HI/LO register.
// Sits in the EX stage beside the ALU and drives the HI/LO write port (we, select, 64-bit data).
// Stalls the pipeline while an operation is in flight.
// Cancels cleanly on exception flush.
// PARAMETERS
// MUL_CYCLES  2   cycles spent in MUL state (>=1); product is computed as a registered multiply
// PORTS
// clk          in   1   clock
// rst          in   1   synchronous, active-high reset
// valid_e      in   1   EX-stage instruction valid
// op_e         in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
// src_a        in   32  rs operand (dividend / multiplicand / MTHI-MTLO data)
// src_b        in   32  rt operand (divisor / multiplier)
// flush_e      in   1   exception flush of EX; aborts any operation
// stall_e      out  1   freeze IF..EX
// hilo_we      out  1   HI/LO write enable
// hilo_select  out  2   2'b00 write both, 2'b11 write HI only, 2'b10 write LO only
// hilo_wdata   out  64  {hi,lo}; for HI-only, upper half is used; for LO-only, lower half is used
// BEHAVIOUR
// - States: IDLE, MUL, DIV, DONE. Reset -> IDLE; counter, operand, result regs = 0.
// - Outputs after reset: stall_e=0, hilo_we=0, hilo_select=0, hilo_wdata=0.
// - start = IDLE & valid_e & !flush_e & op_e in {1..4}. Starts only from IDLE; never from DONE.
// - Start cycle T: latch src_a/src_b/op; stall_e=1 (combinational).
//   - MULT/MULTU -> MUL with count=MUL_CYCLES.
//   - DIV/DIVU, src_b!=0 -> DIV with count=32.
//   - src_b==0 -> DONE directly.
// - MUL: stall_e=1; count decrements each cycle; at count==1 -> DONE. DONE at T+MUL_CYCLES+1.
// - DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, 32 cycles; stall_e=1; DONE at T+33.
// - DONE (one cycle): stall_e=0, hilo_we=1, hilo_select=00, hilo_wdata={hi,lo}; next state IDLE.
// - MULT: signed 64-bit product. MULTU: unsigned 64-bit product.
// - DIV signed:
//   - q sign = sign(a)^sign(b); r sign = sign(a); lo=q, hi=r.
//   - -2^31/-1 gives lo=32'h80000000, hi=0 (wraps).
//   - DIVU unsigned.
// - Divide by zero (DIV or DIVU): lo=32'hFFFF_FFFF, hi=src_a.
// - MTHI in IDLE (valid_e & !flush_e), same cycle, combinational:
//   - hilo_we=1, select=11, wdata={src_a,32'h0}, no stall.
// - MTLO in IDLE, same cycle, combinational:
//   - hilo_we=1, select=10, wdata={32'h0,src_a}, no stall.
// - flush_e=1 in any state:
//   - hilo_we forced 0 and stall_e forced 0 that cycle.
//   - next state IDLE; counter cleared; result discarded.
// - rst mid-operation: same as reset; no write issued.
// - valid_e/op_e changes while in MUL or DIV are ignored; operands come from the latched copies only.
// - In DONE, the stalled instruction is still presented on valid_e/op_e. It is not restarted.
// TESTING
// - MULTU a=FFFFFFFF b=FFFFFFFF -> at T+3 (MUL_CYCLES=2): we=1, sel=00, wdata=FFFFFFFE_00000001; stall 1 over T..T+2.
// - MULT a=-3 b=5 -> wdata=FFFFFFFF_FFFFFFF1.
// - DIV a=-7 b=2 -> at T+33: wdata=FFFFFFFF_FFFFFFFD (hi=-1, lo=-3).
// - DIVU a=100 b=7 -> at T+33: wdata=00000002_0000000E.
// - DIV a=80000000 b=FFFFFFFF -> wdata=00000000_80000000.
// - DIV a=0000_1234 b=0 -> at T+1: wdata=00001234_FFFFFFFF.
// - DIVU start, flush_e at T+10 -> no hilo_we through T+40; stall_e=0 from T+10; next MULT starts normally.
// - MTHI a=AAAA5555 then MTLO a=12345678 back-to-back:
//   - cycle 1: we=1, sel=11, wdata[63:32]=AAAA5555.
//   - cycle 2: we=1, sel=10, wdata[31:0]=12345678.
//   - stall_e stays 0.
// - rst asserted at DIV cycle 5 -> IDLE; outputs 0 next cycle; no write.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer for the EX stage.
//   Runs MULT/MULTU (registered multiply, MUL_CYCLES cycles) and DIV/DIVU
//   (restoring radix-2 on magnitudes, 32 cycles). MTHI/MTLO write HI or LO
//   in the same cycle. The pipeline is stalled while an operation is in flight.
//   An exception flush aborts the operation and discards the result.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   valid_e, op_e      EX-stage instruction valid and opcode (0 none, 1 MULT,
//                      2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none)
//   src_a, src_b       rs / rt operands
//   flush_e            exception flush of EX
//   stall_e            freeze IF..EX
//   hilo_we            HI/LO write enable
//   hilo_select        00 both, 11 HI only, 10 LO only
//   hilo_wdata         {hi, lo}
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_e,
  input  logic [2:0]  op_e,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush_e,
  output logic        stall_e,
  output logic        hilo_we,
  output logic [1:0]  hilo_select,
  output logic [63:0] hilo_wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]  state_r;
  logic [7:0]  count_r;
  logic [31:0] a_r;        // multiplicand (raw)
  logic [31:0] b_r;        // multiplier (raw) or divisor magnitude
  logic        signed_r;   // signed multiply
  logic        neg_q_r;    // quotient must be negated at the end
  logic        neg_r_r;    // remainder must be negated at the end
  logic [31:0] rem_r;      // partial remainder
  logic [31:0] quo_r;      // dividend shifting out, quotient shifting in
  logic [63:0] result_r;

  logic        start_s;
  logic        div_signed_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic [31:0] new_rem_s;
  logic [31:0] new_quo_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;

  // Start detection and operand conditioning for the first cycle.
  always_comb begin
    start_s      = (state_r == ST_IDLE) && valid_e && !flush_e &&
                   (op_e >= OP_MULT) && (op_e <= OP_DIVU);
    div_signed_s = (op_e == OP_DIV);
    a_mag_s      = (div_signed_s && src_a[31]) ? (32'd0 - src_a) : src_a;
    b_mag_s      = (div_signed_s && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

  // Datapath: 64-bit product of the latched operands (sign- or zero-extended),
  // and one restoring-division step. The remainder is always < divisor, so a
  // 33-bit difference is enough and its top bit is the "does not fit" flag.
  always_comb begin
    a_ext_s   = {{32{signed_r & a_r[31]}}, a_r};
    b_ext_s   = {{32{signed_r & b_r[31]}}, b_r};
    prod_s    = a_ext_s * b_ext_s;
    shifted_s = {rem_r, quo_r[31]};
    diff_s    = shifted_s - {1'b0, b_r};
    if (diff_s[32]) begin
      new_rem_s = shifted_s[31:0];
    end else begin
      new_rem_s = diff_s[31:0];
    end
    new_quo_s = {quo_r[30:0], ~diff_s[32]};
    q_fix_s   = neg_q_r ? (32'd0 - new_quo_s) : new_quo_s;
    r_fix_s   = neg_r_r ? (32'd0 - new_rem_s) : new_rem_s;
  end

  // Sequencer state, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      count_r  <= 8'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      signed_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      result_r <= 64'd0;
    end else if (flush_e) begin
      state_r  <= ST_IDLE;
      count_r  <= 8'd0;
      result_r <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            if ((op_e == OP_MULT) || (op_e == OP_MULTU)) begin
              state_r  <= ST_MUL;
              count_r  <= 8'(MUL_CYCLES);
              a_r      <= src_a;
              b_r      <= src_b;
              signed_r <= (op_e == OP_MULT);
            end else if (src_b == 32'd0) begin
              state_r  <= ST_DONE;
              result_r <= {src_a, 32'hFFFF_FFFF};
            end else begin
              state_r  <= ST_DIV;
              count_r  <= 8'd32;
              b_r      <= b_mag_s;
              rem_r    <= 32'd0;
              quo_r    <= a_mag_s;
              neg_q_r  <= div_signed_s & (src_a[31] ^ src_b[31]);
              neg_r_r  <= div_signed_s & src_a[31];
            end
          end
        end
        ST_MUL: begin
          result_r <= prod_s;
          if (count_r == 8'd1) begin
            state_r <= ST_DONE;
          end else begin
            count_r <= count_r - 8'd1;
          end
        end
        ST_DIV: begin
          rem_r <= new_rem_s;
          quo_r <= new_quo_s;
          if (count_r == 8'd1) begin
            state_r  <= ST_DONE;
            count_r  <= 8'd0;
            result_r <= {r_fix_s, q_fix_s};
          end else begin
            count_r <= count_r - 8'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          count_r <= 8'd0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; a flush suppresses both the write and the stall.
  always_comb begin
    stall_e     = 1'b0;
    hilo_we     = 1'b0;
    hilo_select = 2'b00;
    hilo_wdata  = 64'd0;
    if (flush_e) begin
      stall_e = 1'b0;
      hilo_we = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            stall_e = 1'b1;
          end else if (valid_e && (op_e == OP_MTHI)) begin
            hilo_we     = 1'b1;
            hilo_select = 2'b11;
            hilo_wdata  = {src_a, 32'h0000_0000};
          end else if (valid_e && (op_e == OP_MTLO)) begin
            hilo_we     = 1'b1;
            hilo_select = 2'b10;
            hilo_wdata  = {32'h0000_0000, src_a};
          end else begin
            stall_e = 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          stall_e = 1'b1;
        end
        ST_DONE: begin
          hilo_we     = 1'b1;
          hilo_select = 2'b00;
          hilo_wdata  = result_r;
        end
        default: begin
          stall_e = 1'b0;
        end
      endcase
    end
  end

endmodule
